// File: rtl/panel_pkg.sv
// Shared types and helpers for the memory front-panel controller:
// FSM encoding, button indices, segment-count helper and hex-to-7seg table.
package panel_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  localparam int BTN_LATCH = 0;
  localparam int BTN_SEG   = 1;
  localparam int BTN_WRITE = 2;
  localparam int BTN_STEP  = 3;
  localparam int NBTN      = 4;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Cathode pattern {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// Button debouncer: the output toggles once the raw input has disagreed with it
// for DB_CYCLES consecutive cycles; any agreement restarts the count.
module panel_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic db_o
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             db_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (raw_i != db_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        cnt_q <= '0;
        db_q  <= ~db_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/mem_panel_ctrl.sv
// Front-panel controller: switches/buttons to a synchronous memory port.
// Define MEM_PANEL_SEG_EN to build the 4-digit hex display multiplexer.
module mem_panel_ctrl
  import panel_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int SW_W      = 16,
  parameter int SEG_W     = 8,
  parameter int DB_CYCLES = 50000,
  parameter int RD_LAT    = 1,
  parameter int AUTO_INC  = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          btn_latch,
  input  logic                                          btn_seg,
  input  logic                                          btn_write,
  input  logic                                          btn_step,
  input  logic [SW_W-1:0]                               sw,
  output logic [ADDR_W-1:0]                             mem_addr,
  output logic [DATA_W-1:0]                             mem_wdata,
  output logic                                          mem_we,
  input  logic [DATA_W-1:0]                             mem_rdata,
  output logic [DATA_W-1:0]                             led,
  output logic [$clog2((ADDR_W + SEG_W - 1) / SEG_W):0] seg_idx,
  output logic                                          busy,
  output logic [6:0]                                    seg_n,
  output logic [3:0]                                    an_n
);

  localparam int NSEG     = ceil_div(ADDR_W, SEG_W);
  localparam int SEGIDX_W = $clog2(NSEG) + 1;
  localparam int WCNT_W   = $clog2(RD_LAT + 1);

  logic [NBTN-1:0]     raw_s;
  logic [NBTN-1:0]     db_s;
  logic [NBTN-1:0]     db_prev_q;
  logic [NBTN-1:0]     rise_s;
  logic [ADDR_W-1:0]   latch_addr_s;

  state_e              state_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   led_q;
  logic [SEGIDX_W-1:0] seg_idx_q;
  logic                busy_q;
  logic [WCNT_W-1:0]   wait_q;

  assign raw_s[BTN_LATCH] = btn_latch;
  assign raw_s[BTN_SEG]   = btn_seg;
  assign raw_s[BTN_WRITE] = btn_write;
  assign raw_s[BTN_STEP]  = btn_step;

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw_i (raw_s[i]),
      .db_o  (db_s[i])
    );
  end

  assign rise_s = db_s & ~db_prev_q;

  // Address with the selected segment replaced by switch bits; bits past ADDR_W fall away.
  always_comb begin
    latch_addr_s = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      latch_addr_s[b] = (seg_idx_q == SEGIDX_W'(b / SEG_W)) ? sw[b % SEG_W] : mem_addr_q[b];
    end
  end

  // Command FSM; only one command is taken per IDLE cycle, in priority order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      led_q       <= '0;
      seg_idx_q   <= '0;
      busy_q      <= 1'b0;
      wait_q      <= '0;
      db_prev_q   <= '0;
    end else begin
      db_prev_q <= db_s;
      case (state_q)
        S_IDLE: begin
          if (rise_s[BTN_WRITE]) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= sw[DATA_W-1:0];
            busy_q      <= 1'b1;
            state_q     <= S_WRITE;
          end else if (rise_s[BTN_STEP]) begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            wait_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_WAIT;
          end else if (rise_s[BTN_LATCH]) begin
            mem_addr_q <= latch_addr_s;
            wait_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_WAIT;
          end else if (rise_s[BTN_SEG]) begin
            seg_idx_q <= (seg_idx_q == SEGIDX_W'(NSEG - 1)) ? '0 : seg_idx_q + SEGIDX_W'(1);
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WRITE: begin
          mem_we_q <= 1'b0;
          if (AUTO_INC != 0) begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
          end else begin
            mem_addr_q <= mem_addr_q;
          end
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WCNT_W'(RD_LAT - 1)) begin
            state_q <= S_CAPTURE;
          end else begin
            wait_q <= wait_q + WCNT_W'(1);
          end
        end
        S_CAPTURE: begin
          led_q   <= mem_rdata;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign led       = led_q;
  assign seg_idx   = seg_idx_q;
  assign busy      = busy_q;

`ifdef MEM_PANEL_SEG_EN
  localparam int REFRESH_W  = 17;
  localparam int LONG_PRESS = 8 * DB_CYCLES;
  localparam int HOLD_W     = $clog2(LONG_PRESS + 1);

  logic [REFRESH_W+1:0] refresh_q;
  logic [HOLD_W-1:0]    hold_q;
  logic                 show_addr_q;
  logic [6:0]           seg_n_q;
  logic [3:0]           an_n_q;
  logic [15:0]          disp_s;
  logic [1:0]           digit_s;
  logic [3:0]           nib_s;

  assign disp_s  = show_addr_q ? 16'(mem_addr_q) : 16'(led_q);
  assign digit_s = refresh_q[REFRESH_W+1:REFRESH_W];
  assign nib_s   = disp_s[digit_s*4 +: 4];

  // Digit scan plus long-press source toggle; the hold counter saturates so one press toggles once.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q   <= '0;
      hold_q      <= '0;
      show_addr_q <= 1'b0;
      seg_n_q     <= 7'h7F;
      an_n_q      <= 4'hF;
    end else begin
      refresh_q <= refresh_q + (REFRESH_W + 2)'(1);
      if (!db_s[BTN_SEG]) begin
        hold_q <= '0;
      end else if (hold_q == HOLD_W'(LONG_PRESS - 1)) begin
        hold_q      <= hold_q + HOLD_W'(1);
        show_addr_q <= ~show_addr_q;
      end else if (hold_q < HOLD_W'(LONG_PRESS)) begin
        hold_q <= hold_q + HOLD_W'(1);
      end else begin
        hold_q <= hold_q;
      end
      seg_n_q <= hex_to_seg(nib_s);
      an_n_q  <= ~(4'b0001 << digit_s);
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;
`else
  assign seg_n = 7'h7F;
  assign an_n  = 4'hF;
`endif

endmodule
